// File: rtl/rob_commit_tracker.sv
// rob_commit_tracker: in-order reorder tracker opposite rename. Allocates up to two
// entries per cycle, marks writebacks done, retires up to two per cycle in order, and
// on a branch flush walks squashed entries youngest-first (flushed=1) for preg reclaim.
// Ports: clk/rst_n (sync active-low); req_* (two alloc slots); status_* (ticket/full/
// two-free); wb_* (two completions); flush_*; commit_* (two retire/squash slots); busy_o.
// Latency: commit_* are registered one cycle after the deciding state; status_* and
// busy_o decode registered state only, so no input reaches an output combinationally.
module rob_commit_tracker #(
  parameter int ROB_ENTRIES    = 8,
  parameter int ROB_INDEX_BITS = 3,
  parameter int P_ADDR_WIDTH   = 6,
  parameter int L_ADDR_WIDTH   = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid_1,
  input  logic                      req_valid_2,
  input  logic                      req_valid_dest_1,
  input  logic                      req_valid_dest_2,
  input  logic [L_ADDR_WIDTH-1:0]   req_lreg_1,
  input  logic [L_ADDR_WIDTH-1:0]   req_lreg_2,
  input  logic [P_ADDR_WIDTH-1:0]   req_preg_1,
  input  logic [P_ADDR_WIDTH-1:0]   req_preg_2,
  input  logic [P_ADDR_WIDTH-1:0]   req_ppreg_1,
  input  logic [P_ADDR_WIDTH-1:0]   req_ppreg_2,
  output logic [ROB_INDEX_BITS-1:0] status_ticket,
  output logic                      status_is_full,
  output logic                      status_two_empty,
  input  logic                      wb_valid_1,
  input  logic                      wb_valid_2,
  input  logic [ROB_INDEX_BITS-1:0] wb_ticket_1,
  input  logic [ROB_INDEX_BITS-1:0] wb_ticket_2,
  input  logic                      flush_valid,
  input  logic [ROB_INDEX_BITS-1:0] flush_ticket,
  output logic                      commit_valid_1,
  output logic                      commit_valid_2,
  output logic [L_ADDR_WIDTH-1:0]   commit_ldst_1,
  output logic [L_ADDR_WIDTH-1:0]   commit_ldst_2,
  output logic [P_ADDR_WIDTH-1:0]   commit_pdst_1,
  output logic [P_ADDR_WIDTH-1:0]   commit_pdst_2,
  output logic [P_ADDR_WIDTH-1:0]   commit_ppdst_1,
  output logic [P_ADDR_WIDTH-1:0]   commit_ppdst_2,
  output logic                      commit_flushed_1,
  output logic                      commit_flushed_2,
  output logic                      busy_o
);

  localparam int IB = ROB_INDEX_BITS;
  localparam int CW = ROB_INDEX_BITS + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(ROB_ENTRIES);
  localparam logic [CW-1:0] TWO_CNT  = CW'(ROB_ENTRIES - 2);

  typedef enum logic {NORMAL = 1'b0, FLUSH = 1'b1} state_t;

  state_t                  state;
  logic [IB-1:0]           head, tail, walk, fstop;
  logic [CW-1:0]           count;
  logic [ROB_ENTRIES-1:0]  ent_valid, ent_done, ent_dest;
  logic [L_ADDR_WIDTH-1:0] ent_lreg  [ROB_ENTRIES];
  logic [P_ADDR_WIDTH-1:0] ent_preg  [ROB_ENTRIES];
  logic [P_ADDR_WIDTH-1:0] ent_ppreg [ROB_ENTRIES];

  logic [IB-1:0]           head_p1, walk_m1, flush_nx, rem, req2_idx, cm1_idx, cm2_idx;
  logic                    fire_1, fire_2, sq_2, sq_last, alloc_1, alloc_2, flush_go;
  logic                    cm1_v, cm2_v, cm_f;
  logic [CW-1:0]           n_commit, n_alloc, n_sq;
  logic [ROB_ENTRIES-1:0]  valid_nx, done_nx;

  assign status_ticket    = tail;
  assign status_is_full   = (state == FLUSH) || (count == FULL_CNT);
  assign status_two_empty = (state == NORMAL) && (count <= TWO_CNT);
  assign busy_o           = (state == FLUSH);

  always_comb begin
    head_p1  = head + IB'(1);
    walk_m1  = walk - IB'(1);
    flush_nx = flush_ticket + IB'(1);
    // Entries still to squash beyond the current walk slot; 0 means walk is the last.
    rem      = walk - fstop;
    fire_1   = (state == NORMAL) && ent_valid[head] && ent_done[head];
    fire_2   = fire_1 && ent_valid[head_p1] && ent_done[head_p1];
    sq_2     = (state == FLUSH) && (rem != '0);
    sq_last  = (state == FLUSH) && (rem <= IB'(1));
    alloc_1  = (state == NORMAL) && !flush_valid && req_valid_1 && !status_is_full;
    alloc_2  = (state == NORMAL) && !flush_valid && req_valid_2 && status_two_empty;
    req2_idx = tail + IB'(alloc_1);
    flush_go = (state == NORMAL) && flush_valid && (flush_nx != tail);
    n_commit = CW'(fire_1) + CW'(fire_2);
    n_alloc  = CW'(alloc_1) + CW'(alloc_2);
    n_sq     = (state == FLUSH) ? (sq_2 ? CW'(2) : CW'(1)) : '0;

    cm_f     = (state == FLUSH);
    cm1_v    = fire_1 || cm_f;
    cm2_v    = fire_2 || sq_2;
    cm1_idx  = cm_f ? walk    : head;
    cm2_idx  = cm_f ? walk_m1 : head_p1;

    // Order matters: retire/squash clears, then allocation overrides writeback.
    valid_nx = ent_valid;
    done_nx  = ent_done;
    if (wb_valid_1 && ent_valid[wb_ticket_1]) done_nx[wb_ticket_1] = 1'b1;
    if (wb_valid_2 && ent_valid[wb_ticket_2]) done_nx[wb_ticket_2] = 1'b1;
    if (cm1_v) valid_nx[cm1_idx] = 1'b0;
    if (cm2_v) valid_nx[cm2_idx] = 1'b0;
    if (alloc_1) begin
      valid_nx[tail] = 1'b1;
      done_nx[tail]  = 1'b0;
    end
    if (alloc_2) begin
      valid_nx[req2_idx] = 1'b1;
      done_nx[req2_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= NORMAL;
      head             <= '0;
      tail             <= '0;
      walk             <= '0;
      fstop            <= '0;
      count            <= '0;
      ent_valid        <= '0;
      ent_done         <= '0;
      commit_valid_1   <= 1'b0;
      commit_valid_2   <= 1'b0;
      commit_ldst_1    <= '0;
      commit_ldst_2    <= '0;
      commit_pdst_1    <= '0;
      commit_pdst_2    <= '0;
      commit_ppdst_1   <= '0;
      commit_ppdst_2   <= '0;
      commit_flushed_1 <= 1'b0;
      commit_flushed_2 <= 1'b0;
    end else begin
      ent_valid <= valid_nx;
      ent_done  <= done_nx;
      head      <= head + IB'(fire_1) + IB'(fire_2);
      count     <= count + n_alloc - n_commit - n_sq;

      case (state)
        NORMAL: begin
          tail <= tail + IB'(alloc_1) + IB'(alloc_2);
          if (flush_go) begin
            state <= FLUSH;
            walk  <= tail - IB'(1);
            fstop <= flush_nx;
          end
        end
        FLUSH: begin
          walk <= sq_2 ? (walk - IB'(2)) : walk_m1;
          if (sq_last) begin
            tail  <= fstop;
            state <= NORMAL;
          end
        end
        default: state <= NORMAL;
      endcase

      commit_valid_1   <= cm1_v;
      commit_valid_2   <= cm2_v;
      commit_ldst_1    <= (cm1_v && ent_dest[cm1_idx]) ? ent_lreg[cm1_idx] : '0;
      commit_ldst_2    <= (cm2_v && ent_dest[cm2_idx]) ? ent_lreg[cm2_idx] : '0;
      commit_pdst_1    <= cm1_v ? ent_preg[cm1_idx]  : '0;
      commit_pdst_2    <= cm2_v ? ent_preg[cm2_idx]  : '0;
      commit_ppdst_1   <= cm1_v ? ent_ppreg[cm1_idx] : '0;
      commit_ppdst_2   <= cm2_v ? ent_ppreg[cm2_idx] : '0;
      commit_flushed_1 <= cm1_v && cm_f;
      commit_flushed_2 <= cm2_v && cm_f;
    end
  end

  // Payload needs no reset: it is only observed through a valid entry.
  always_ff @(posedge clk) begin
    if (alloc_1) begin
      ent_dest[tail]  <= req_valid_dest_1;
      ent_lreg[tail]  <= req_lreg_1;
      ent_preg[tail]  <= req_preg_1;
      ent_ppreg[tail] <= req_ppreg_1;
    end
    if (alloc_2) begin
      ent_dest[req2_idx]  <= req_valid_dest_2;
      ent_lreg[req2_idx]  <= req_lreg_2;
      ent_preg[req2_idx]  <= req_preg_2;
      ent_ppreg[req2_idx] <= req_ppreg_2;
    end
  end

  // Rename must not request beyond advertised space; such requests are dropped.
  alloc_refused_a: assert property (@(posedge clk) disable iff (!rst_n)
      !((req_valid_1 && status_is_full) || (req_valid_2 && !status_two_empty)))
    else $warning("rob_commit_tracker: allocation request while ROB cannot accept it");

endmodule

// File: tb/tb_rob_commit_tracker.sv
// tb_rob_commit_tracker: directed scenarios plus randomized traffic for rob_commit_tracker,
// each cycle compared against a queue-based program-order model of the ROB.
module tb_rob_commit_tracker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid_1, req_valid_2, req_valid_dest_1, req_valid_dest_2;
  logic [4:0] req_lreg_1, req_lreg_2;
  logic [5:0] req_preg_1, req_preg_2, req_ppreg_1, req_ppreg_2;
  logic [2:0] status_ticket;
  logic       status_is_full, status_two_empty;
  logic       wb_valid_1, wb_valid_2;
  logic [2:0] wb_ticket_1, wb_ticket_2;
  logic       flush_valid;
  logic [2:0] flush_ticket;
  logic       commit_valid_1, commit_valid_2;
  logic [4:0] commit_ldst_1, commit_ldst_2;
  logic [5:0] commit_pdst_1, commit_pdst_2, commit_ppdst_1, commit_ppdst_2;
  logic       commit_flushed_1, commit_flushed_2;
  logic       busy_o;

  always #5 clk = ~clk;

  rob_commit_tracker dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_1(req_valid_1), .req_valid_2(req_valid_2),
    .req_valid_dest_1(req_valid_dest_1), .req_valid_dest_2(req_valid_dest_2),
    .req_lreg_1(req_lreg_1), .req_lreg_2(req_lreg_2),
    .req_preg_1(req_preg_1), .req_preg_2(req_preg_2),
    .req_ppreg_1(req_ppreg_1), .req_ppreg_2(req_ppreg_2),
    .status_ticket(status_ticket), .status_is_full(status_is_full),
    .status_two_empty(status_two_empty),
    .wb_valid_1(wb_valid_1), .wb_valid_2(wb_valid_2),
    .wb_ticket_1(wb_ticket_1), .wb_ticket_2(wb_ticket_2),
    .flush_valid(flush_valid), .flush_ticket(flush_ticket),
    .commit_valid_1(commit_valid_1), .commit_valid_2(commit_valid_2),
    .commit_ldst_1(commit_ldst_1), .commit_ldst_2(commit_ldst_2),
    .commit_pdst_1(commit_pdst_1), .commit_pdst_2(commit_pdst_2),
    .commit_ppdst_1(commit_ppdst_1), .commit_ppdst_2(commit_ppdst_2),
    .commit_flushed_1(commit_flushed_1), .commit_flushed_2(commit_flushed_2),
    .busy_o(busy_o)
  );

  typedef struct {int t; int lreg; int preg; int ppreg; bit dest; bit done;} ent_t;
  typedef struct {bit v; int l; int p; int pp; bit f;} cm_t;

  ent_t q[$];      // live entries, oldest first
  ent_t sq[$];     // squashed entries awaiting emission, youngest first
  int   m_tail;
  bit   m_fl;
  int   m_ft;
  cm_t  e1, e2;
  int   pdst_log[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic cm_t to_cm(input ent_t e, input bit f);
    cm_t c;
    c.v  = 1'b1;
    c.l  = e.dest ? e.lreg : 0;
    c.p  = e.preg;
    c.pp = e.ppreg;
    c.f  = f;
    return c;
  endfunction

  task automatic apply_wb();
    foreach (q[i]) begin
      if (wb_valid_1 && q[i].t == int'(wb_ticket_1)) q[i].done = 1'b1;
      if (wb_valid_2 && q[i].t == int'(wb_ticket_2)) q[i].done = 1'b1;
    end
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    cm_t  z;
    ent_t e;
    int   n_c;
    bit   full, two;
    z  = '{v: 1'b0, l: 0, p: 0, pp: 0, f: 1'b0};
    e1 = z;
    e2 = z;
    if (!rst_n) begin
      q.delete();
      sq.delete();
      m_tail = 0;
      m_fl   = 1'b0;
      return;
    end
    if (!m_fl) begin
      full = (q.size() == 8);
      two  = (q.size() <= 6);
      n_c  = 0;
      if (q.size() >= 1 && q[0].done) begin
        e1 = to_cm(q[0], 1'b0);
        n_c = 1;
        if (q.size() >= 2 && q[1].done) begin
          e2 = to_cm(q[1], 1'b0);
          n_c = 2;
        end
      end
      apply_wb();
      repeat (n_c) void'(q.pop_front());
      if (flush_valid) begin
        if (((int'(flush_ticket) + 1) % 8) != m_tail) begin
          m_fl = 1'b1;
          m_ft = int'(flush_ticket);
          while (q.size() > 0 && q[$].t != m_ft) sq.push_back(q.pop_back());
        end
      end else begin
        if (req_valid_1 && !full) begin
          e = '{t: m_tail, lreg: int'(req_lreg_1), preg: int'(req_preg_1),
                ppreg: int'(req_ppreg_1), dest: req_valid_dest_1, done: 1'b0};
          q.push_back(e);
          m_tail = (m_tail + 1) % 8;
        end
        if (req_valid_2 && two) begin
          e = '{t: m_tail, lreg: int'(req_lreg_2), preg: int'(req_preg_2),
                ppreg: int'(req_ppreg_2), dest: req_valid_dest_2, done: 1'b0};
          q.push_back(e);
          m_tail = (m_tail + 1) % 8;
        end
      end
    end else begin
      apply_wb();
      e1 = to_cm(sq.pop_front(), 1'b1);
      if (sq.size() > 0) e2 = to_cm(sq.pop_front(), 1'b1);
      if (sq.size() == 0) begin
        m_fl   = 1'b0;
        m_tail = (m_ft + 1) % 8;
      end
    end
  endtask

  task automatic compare();
    chk("ticket",    int'(status_ticket),    m_tail);
    chk("is_full",   int'(status_is_full),   int'(m_fl || q.size() == 8));
    chk("two_empty", int'(status_two_empty), int'(!m_fl && q.size() <= 6));
    chk("busy",      int'(busy_o),           int'(m_fl));
    chk("cv1",       int'(commit_valid_1),   int'(e1.v));
    chk("ldst1",     int'(commit_ldst_1),    e1.l);
    chk("pdst1",     int'(commit_pdst_1),    e1.p);
    chk("ppdst1",    int'(commit_ppdst_1),   e1.pp);
    chk("flushed1",  int'(commit_flushed_1), int'(e1.f));
    chk("cv2",       int'(commit_valid_2),   int'(e2.v));
    chk("ldst2",     int'(commit_ldst_2),    e2.l);
    chk("pdst2",     int'(commit_pdst_2),    e2.p);
    chk("ppdst2",    int'(commit_ppdst_2),   e2.pp);
    chk("flushed2",  int'(commit_flushed_2), int'(e2.f));
    if (commit_valid_1) pdst_log.push_back(int'(commit_pdst_1));
    if (commit_valid_2) pdst_log.push_back(int'(commit_pdst_2));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic idle();
    rst_n = 1'b1;
    req_valid_1 = 1'b0; req_valid_2 = 1'b0;
    req_valid_dest_1 = 1'b0; req_valid_dest_2 = 1'b0;
    req_lreg_1 = '0; req_lreg_2 = '0;
    req_preg_1 = '0; req_preg_2 = '0;
    req_ppreg_1 = '0; req_ppreg_2 = '0;
    wb_valid_1 = 1'b0; wb_valid_2 = 1'b0;
    wb_ticket_1 = '0; wb_ticket_2 = '0;
    flush_valid = 1'b0; flush_ticket = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    idle();
  endtask

  task automatic req1(input int l, input int p, input int pp);
    req_valid_1 = 1'b1; req_valid_dest_1 = 1'b1;
    req_lreg_1 = 5'(l); req_preg_1 = 6'(p); req_ppreg_1 = 6'(pp);
  endtask

  task automatic req2(input int l, input int p, input int pp);
    req_valid_2 = 1'b1; req_valid_dest_2 = 1'b1;
    req_lreg_2 = 5'(l); req_preg_2 = 6'(p); req_ppreg_2 = 6'(pp);
  endtask

  task automatic rand_inputs();
    int k;
    idle();
    if ($urandom_range(0, 149) == 0) begin
      rst_n = 1'b0;
      return;
    end
    if (!m_fl) begin
      if (q.size() < 8 && $urandom_range(0, 2) != 0) begin
        req_valid_1 = 1'b1; req_valid_dest_1 = 1'($urandom_range(0, 1));
        req_lreg_1 = 5'($urandom_range(0, 31)); req_preg_1 = 6'($urandom_range(0, 63));
        req_ppreg_1 = 6'($urandom_range(0, 63));
      end
      if (q.size() <= 6 && $urandom_range(0, 2) == 0) begin
        req_valid_2 = 1'b1; req_valid_dest_2 = 1'($urandom_range(0, 1));
        req_lreg_2 = 5'($urandom_range(0, 31)); req_preg_2 = 6'($urandom_range(0, 63));
        req_ppreg_2 = 6'($urandom_range(0, 63));
      end
      if (q.size() >= 2 && $urandom_range(0, 11) == 0) begin
        flush_valid = 1'b1;
        k = $urandom_range(1, q.size() - 1);
        flush_ticket = 3'(q[k].t);
      end
    end else begin
      flush_valid  = 1'($urandom_range(0, 1));
      flush_ticket = 3'($urandom_range(0, 7));
    end
    wb_valid_1 = 1'($urandom_range(0, 1));
    wb_valid_2 = 1'($urandom_range(0, 1));
    wb_ticket_1 = (q.size() > 0) ? 3'(q[$urandom_range(0, q.size() - 1)].t)
                                 : 3'($urandom_range(0, 7));
    wb_ticket_2 = 3'($urandom_range(0, 7));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    step();
    step();
    idle();
    step();
    chk("rst_ticket", int'(status_ticket), 0);
    chk("rst_full",   int'(status_is_full), 0);
    chk("rst_two",    int'(status_two_empty), 1);
    chk("rst_cv",     int'(commit_valid_1 || commit_valid_2 || busy_o), 0);

    // Dual allocation, out-of-order completion, paired retirement.
    req1(3, 40, 3); req2(5, 41, 5); step();
    idle(); wb_valid_1 = 1'b1; wb_ticket_1 = 3'd1; step();
    chk("dual_wait1", int'(commit_valid_1), 0);
    idle(); wb_valid_1 = 1'b1; wb_ticket_1 = 3'd0; step();
    chk("dual_wait2", int'(commit_valid_1), 0);
    idle(); step();
    chk("dual_cv1", int'(commit_valid_1), 1);
    chk("dual_l1",  int'(commit_ldst_1), 3);
    chk("dual_p1",  int'(commit_pdst_1), 40);
    chk("dual_pp1", int'(commit_ppdst_1), 3);
    chk("dual_cv2", int'(commit_valid_2), 1);
    chk("dual_l2",  int'(commit_ldst_2), 5);
    chk("dual_p2",  int'(commit_pdst_2), 41);
    chk("dual_pp2", int'(commit_ppdst_2), 5);
    chk("dual_f",   int'(commit_flushed_1 || commit_flushed_2), 0);

    // Fill to capacity; one more request is dropped.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); req1(i, 8 + i, i); step();
      if (i == 6) begin
        chk("fill7_two",  int'(status_two_empty), 0);
        chk("fill7_full", int'(status_is_full), 0);
      end
      if (i == 7) chk("fill8_full", int'(status_is_full), 1);
    end
    idle(); req1(9, 9, 9); step();
    chk("over_ticket", int'(status_ticket), 0);
    chk("over_full",   int'(status_is_full), 1);

    // Flush after ticket 2 with six entries: squash 5,4 then 3.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); req1(2 * i, 20 + 2 * i, 1); req2(2 * i + 1, 21 + 2 * i, 1); step();
    end
    idle(); flush_valid = 1'b1; flush_ticket = 3'd2; step();
    chk("fl_busy0", int'(busy_o), 1);
    idle(); step();
    chk("fl_busy1", int'(busy_o), 1);
    chk("fl_p1a",   int'(commit_pdst_1), 25);
    chk("fl_p2a",   int'(commit_pdst_2), 24);
    chk("fl_fa",    int'(commit_flushed_1 && commit_flushed_2), 1);
    idle(); step();
    chk("fl_busy2", int'(busy_o), 0);
    chk("fl_p1b",   int'(commit_pdst_1), 23);
    chk("fl_f1b",   int'(commit_flushed_1), 1);
    chk("fl_cv2b",  int'(commit_valid_2), 0);
    chk("fl_ticket", int'(status_ticket), 3);
    chk("fl_two",   int'(status_two_empty), 1);

    // Move head to 6, then allocate/retire across the wrap.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      idle(); req1(1, 1, 1); req2(1, 1, 1); step();
    end
    for (int i = 0; i < 3; i++) begin
      idle(); wb_valid_1 = 1'b1; wb_ticket_1 = 3'(2 * i);
      wb_valid_2 = 1'b1; wb_ticket_2 = 3'(2 * i + 1); step();
    end
    idle(); step(); step(); step();
    pdst_log.delete();
    idle(); req1(6, 36, 6); req2(7, 37, 7); step();
    idle(); req1(0, 30, 0); req2(1, 31, 1); step();
    idle(); wb_valid_1 = 1'b1; wb_ticket_1 = 3'd6; wb_valid_2 = 1'b1; wb_ticket_2 = 3'd0; step();
    idle(); wb_valid_1 = 1'b1; wb_ticket_1 = 3'd7; wb_valid_2 = 1'b1; wb_ticket_2 = 3'd1; step();
    idle(); step(); step(); step(); step();
    chk("wrap_n", pdst_log.size(), 4);
    if (pdst_log.size() == 4) begin
      chk("wrap_0", pdst_log[0], 36);
      chk("wrap_1", pdst_log[1], 37);
      chk("wrap_2", pdst_log[2], 30);
      chk("wrap_3", pdst_log[3], 31);
    end
    chk("wrap_ticket", int'(status_ticket), 2);

    // Flush of the youngest ticket is a no-op.
    idle(); flush_valid = 1'b1; flush_ticket = 3'd1; step();
    chk("noop_busy0", int'(busy_o), 0);
    idle(); step();
    chk("noop_busy1", int'(busy_o), 0);
    chk("noop_ticket", int'(status_ticket), 2);

    // Randomized traffic including flushes and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
